// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, shift amount width, shift
// operation encoding and the shift sequencer state encoding.
package alu_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = $clog2(WIDTH);

  // Encoding 2'b11 is not listed and behaves as LOGICAL.
  typedef enum logic [1:0] {
    LOGICAL = 2'b00,
    ARITH   = 2'b01,
    ROTATE  = 2'b10
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } seq_state_t;

endpackage

// File: rtl/shift_unit.sv
// Single-position shift stage. Moves the word one bit left or right and
// chooses the fill bit from the A (arithmetic), R (rotate) and L (logical)
// controls. Arithmetic left is the same as logical left.
module shift_unit #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] din_i,
  input  logic             a_i,
  input  logic             r_i,
  input  logic             l_i,
  input  logic             drxn_i,
  output logic [WIDTH-1:0] dout_o
);

  logic fill_s;

  // Select the fill bit for the vacated position and form the shifted word.
  always_comb begin
    fill_s = 1'b0;
    dout_o = din_i;
    if (drxn_i) begin
      if (r_i) begin
        fill_s = din_i[0];
      end else if (a_i) begin
        fill_s = din_i[WIDTH-1];
      end else if (l_i) begin
        fill_s = 1'b0;
      end else begin
        fill_s = 1'b0;
      end
      dout_o = {fill_s, din_i[WIDTH-1:1]};
    end else begin
      if (r_i) begin
        fill_s = din_i[WIDTH-1];
      end else begin
        fill_s = 1'b0;
      end
      dout_o = {din_i[WIDTH-2:0], fill_s};
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate engine. Latches an operand, amount and control on
// an accepted start, then applies the one-bit shift stage once per clock
// until the amount is used up, and presents the result with a valid pulse.
module shift_sequencer #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [WIDTH-1:0]         operand,
  input  logic [$clog2(WIDTH)-1:0] amount,
  input  logic [1:0]               op,
  input  logic                     drxn,
  output logic                     ready,
  output logic                     busy,
  output logic                     valid,
  output logic [WIDTH-1:0]         result,
  output logic                     carry
);

  import alu_pkg::*;

  localparam int AW = $clog2(WIDTH);

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] step_s;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             drxn_q, drxn_d;
  logic             carry_q, carry_d;
  logic             accept_s;
  logic             arith_s, rot_s, logic_s;
  logic             out_bit_s;

  // Handshake outputs are decoded from the state register only, so there is
  // no combinational path from start to ready.
  assign ready  = (state_q == IDLE) || (state_q == DONE);
  assign busy   = (state_q == SHIFT);
  assign valid  = (state_q == DONE);
  assign result = work_q;
  assign carry  = carry_q;

  assign accept_s = start & ready;

  // Shift stage controls come from the latched op; 2'b11 falls to logical.
  assign arith_s = (op_q == ARITH);
  assign rot_s   = (op_q == ROTATE);
  assign logic_s = ~(arith_s | rot_s);

  // Bit leaving the working register on this step.
  assign out_bit_s = drxn_q ? work_q[0] : work_q[WIDTH-1];

  shift_unit #(
    .WIDTH (WIDTH)
  ) u_shift_unit (
    .din_i  (work_q),
    .a_i    (arith_s),
    .r_i    (rot_s),
    .l_i    (logic_s),
    .drxn_i (drxn_q),
    .dout_o (step_s)
  );

  // Next-state logic: load on accept, step while shifting, count down.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    drxn_d  = drxn_q;
    carry_d = carry_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          work_d  = operand;
          cnt_d   = amount;
          op_d    = op;
          drxn_d  = drxn;
          carry_d = 1'b0;
          if (amount == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d  = step_s;
        carry_d = out_bit_s;
        cnt_d   = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      drxn_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      drxn_q  <= drxn_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: the driver pushes the expected
// result, carry and valid time on each accepted start; a monitor pops and
// compares whenever valid is seen.
module tb_shift_sequencer;

  localparam int  W      = 32;
  localparam time PERIOD = 10;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  operand;
  logic [4:0]    amount;
  logic [1:0]    op;
  logic          drxn;
  logic          ready;
  logic          busy;
  logic          valid;
  logic [W-1:0]  result;
  logic          carry;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    time          t;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks;
  int   errors;
  time  last_accept_t;
  time  first_accept_t;

  shift_sequencer #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .operand (operand),
    .amount  (amount),
    .op      (op),
    .drxn    (drxn),
    .ready   (ready),
    .busy    (busy),
    .valid   (valid),
    .result  (result),
    .carry   (carry)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  // Reference: whole shift by n computed with wide arithmetic. Returns {carry, result}.
  function automatic logic [W:0] ref_shift(logic [W-1:0] v, int n, logic [1:0] o, logic d);
    logic [63:0] w;
    logic [W-1:0] r;
    logic c;
    if (o == 2'b10) begin
      w = {v, v};
      if (!d) begin
        w = w << n;
        r = w[63:32];
        c = r[0];
      end else begin
        w = w >> n;
        r = w[31:0];
        c = r[31];
      end
    end else if (!d) begin
      w = {32'h0, v} << n;
      r = w[31:0];
      c = w[32];
    end else if (o == 2'b01) begin
      w = $unsigned($signed({v, 32'h0}) >>> n);
      r = w[63:32];
      c = w[31];
    end else begin
      w = {v, 32'h0} >> n;
      r = w[63:32];
      c = w[31];
    end
    if (n == 0) c = 1'b0;
    return {c, r};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Wait for ready, present one request, record the expectation at the accept edge.
  task automatic issue(logic [W-1:0] v, int n, logic [1:0] o, logic d);
    int guard;
    logic [W:0] r;
    guard = 0;
    @(negedge clk);
    while (ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (ready !== 1'b1) begin
      fail_now("ready_timeout");
    end else begin
      start   = 1'b1;
      operand = v;
      amount  = 5'(n);
      op      = o;
      drxn    = d;
      @(posedge clk);
      last_accept_t = $time;
      r = ref_shift(v, n, o, d);
      exp_q.push_back('{res: r[W-1:0], c: r[W], t: $time + PERIOD * n + 1});
      #1;
      start   = 1'b0;
      operand = $urandom;
      amount  = 5'($urandom_range(0, 31));
      op      = 2'($urandom_range(0, 3));
      drxn    = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
  endtask

  // Monitor: every valid cycle must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: result %h carry %b with nothing outstanding at %0t",
                 result, carry, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", 64'(result), 64'(mon_e.res));
        check("carry", 64'(carry), 64'(mon_e.c));
        check("valid_time", 64'($time), 64'(mon_e.t));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    operand = '0;
    amount  = '0;
    op      = 2'b00;
    drxn    = 1'b0;
    #2;
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_carry", 64'(carry), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the plan.
    issue(32'h0000_00F1, 4, 2'b00, 1'b0);
    drain();
    issue(32'h8000_0000, 31, 2'b01, 1'b1);
    drain();
    issue(32'h8000_0000, 31, 2'b00, 1'b1);
    drain();
    issue(32'h1234_5678, 8, 2'b10, 1'b0);
    drain();
    issue(32'h0000_0001, 1, 2'b10, 1'b1);
    drain();
    issue(32'hF000_000F, 3, 2'b11, 1'b1);
    drain();

    // amount = 0, then back-to-back start while in DONE.
    issue(32'hDEAD_BEEF, 0, 2'b00, 1'b0);
    first_accept_t = last_accept_t;
    issue(32'h0F0F_0001, 2, 2'b10, 1'b1);
    check("back_to_back_gap", 64'(last_accept_t - first_accept_t), 64'(PERIOD));
    drain();

    // Start pulses during SHIFT are ignored; only one valid must follow.
    issue(32'hA5A5_5A5A, 10, 2'b01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_in_shift", 64'(busy), 64'd1);
      check("ready_in_shift", 64'(ready), 64'd0);
      start   = 1'b1;
      operand = $urandom;
      amount  = 5'd0;
    end
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    // Reset in the middle of a shift: outputs clear at once, no valid afterwards.
    issue(32'h7654_3210, 20, 2'b00, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midreset_ready", 64'(ready), 64'd1);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_valid", 64'(valid), 64'd0);
    check("midreset_result", 64'(result), 64'd0);
    check("midreset_carry", 64'(carry), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    issue(32'h8765_4321, 5, 2'b10, 1'b0);
    drain();

    // Randomised operations, with occasional idle gaps.
    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      issue($urandom, int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
    end
    drain();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
